poly_pingpong_mem: RTL and testbench

- Parametrised ping-pong coefficient store for SNTRUP757 polynomial datapaths.
- Two banks of distributed RAM. The producer always writes the current write bank while the consumer reads the other bank. A swap pulse exchanges the two roles.
- Adds a registered read with valid flag and a hardware clear sequencer that zeroes the first N_COEF entries of the write bank.
- Sits between the arithmetic stages (multiplier, reduction) as a double buffer.

---
 rtl/poly_pingpong_mem.sv | 122 ++++++++++++
 tb/tb_poly_pingpong_mem.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_pingpong_mem.sv
// poly_pingpong_mem: two-bank ping-pong coefficient store.
// The producer writes bank[wr_bank] while the consumer reads bank[~wr_bank];
// a swap pulse exchanges the roles. A small sequencer can zero the first
// N_COEF entries of the write bank, taking over the write port while it runs.
module poly_pingpong_mem #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11,
  parameter int N_COEF        = 757
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     swap,
  input  logic                     clear_start,
  output logic                     clear_busy,
  input  logic                     write_enable,
  input  logic [RAM_ADDR_BITS-1:0] write_address,
  input  logic [RAM_WIDTH-1:0]     input_data,
  input  logic                     read_enable,
  input  logic [RAM_ADDR_BITS-1:0] read_address,
  output logic [RAM_WIDTH-1:0]     output_data,
  output logic                     output_valid,
  output logic                     wr_bank
);

  localparam int DEPTH = 2 ** RAM_ADDR_BITS;
  // Address of the final entry the sequencer zeroes before returning to IDLE.
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(N_COEF - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                     wr_bank_q, wr_bank_d;
  logic [RAM_WIDTH-1:0]     output_data_q, output_data_d;
  logic                     output_valid_q, output_valid_d;

  // Both banks share one array; the MSB of the address selects the bank.
  logic [RAM_WIDTH-1:0]     mem [0:2*DEPTH-1];

  logic                     mem_we;
  logic [RAM_ADDR_BITS:0]   mem_waddr;
  logic [RAM_WIDTH-1:0]     mem_wdata;
  logic [RAM_WIDTH-1:0]     rd_word;

  // The read side always looks at the bank the producer is not using.
  assign rd_word = mem[{~wr_bank_q, read_address}];

  // Next-state logic: the clear sequencer owns the write port and blocks swaps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    mem_we    = 1'b0;
    mem_waddr = {wr_bank_q, write_address};
    mem_wdata = input_data;
    case (state_q)
      IDLE: begin
        mem_we = write_enable;
        if (swap) begin
          wr_bank_d = ~wr_bank_q;
        end
        // The clear begins on the next cycle, so it lands in the post-swap bank.
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = {wr_bank_q, cnt_q};
        mem_wdata = '0;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + RAM_ADDR_BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read-path next values: capture on a strobe, otherwise hold the last word.
  always_comb begin
    output_valid_d = read_enable;
    output_data_d  = read_enable ? rd_word : output_data_q;
  end

  // Control and output registers; reset aborts any clear in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wr_bank_q      <= 1'b0;
      output_data_q  <= '0;
      output_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_bank_q      <= wr_bank_d;
      output_data_q  <= output_data_d;
      output_valid_q <= output_valid_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign clear_busy   = (state_q == CLEAR);
  assign output_data  = output_data_q;
  assign output_valid = output_valid_q;
  assign wr_bank      = wr_bank_q;

endmodule

// File: tb/tb_poly_pingpong_mem.sv
// Testbench for poly_pingpong_mem: randomized traffic against a bank-array
// reference model plus directed ping-pong, clear and reset scenarios.
module tb_poly_pingpong_mem;

  localparam int W  = 13;
  localparam int AB = 11;
  localparam int N  = 757;
  localparam int D  = 2 ** AB;

  logic          clk = 1'b0;
  logic          rst;
  logic          swap, clear_start, clear_busy;
  logic          write_enable, read_enable, output_valid, wr_bank;
  logic [AB-1:0] write_address, read_address;
  logic [W-1:0]  input_data, output_data;

  always #5 clk = ~clk;

  poly_pingpong_mem #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .N_COEF(N)) dut (
    .clk(clk), .rst(rst), .swap(swap), .clear_start(clear_start),
    .clear_busy(clear_busy), .write_enable(write_enable),
    .write_address(write_address), .input_data(input_data),
    .read_enable(read_enable), .read_address(read_address),
    .output_data(output_data), .output_valid(output_valid), .wr_bank(wr_bank)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: two plain bank arrays plus role bit and clear progress.
  logic [W-1:0] mdl [2][D];
  bit           m_bank;
  bit           m_busy;
  int           m_left;
  int           m_idx;
  logic [W-1:0] m_data;
  bit           m_valid;

  task automatic idle_inputs();
    swap = 0; clear_start = 0; write_enable = 0; read_enable = 0;
    write_address = '0; read_address = '0; input_data = '0;
  endtask

  // One clock edge: apply the behavioural rules to the model using the
  // inputs and roles that were present just before the edge.
  task automatic tick();
    @(posedge clk);
    if (read_enable) begin
      m_data  = mdl[!m_bank][read_address];
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    if (m_busy) begin
      mdl[m_bank][m_idx] = '0;
      m_idx++;
      m_left--;
      if (m_left == 0) m_busy = 0;
    end else begin
      if (write_enable) mdl[m_bank][write_address] = input_data;
      if (swap) m_bank = !m_bank;
      if (clear_start) begin
        m_busy = 1; m_idx = 0; m_left = N;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_bank = 0; m_busy = 0; m_data = '0; m_valid = 0; m_idx = 0; m_left = 0;
  endtask

  // Issue one read of the read bank and return what the DUT produced.
  task automatic read_cell(input int addr, output logic [W-1:0] got, output logic vld);
    read_enable = 1; read_address = AB'(addr);
    tick();
    read_enable = 0;
    got = output_data; vld = output_valid;
  endtask

  task automatic write_cell(input int addr, input logic [W-1:0] val);
    write_enable = 1; write_address = AB'(addr); input_data = val;
    tick();
    write_enable = 0;
  endtask

  task automatic pulse_swap();
    swap = 1; tick(); swap = 0;
  endtask

  task automatic wait_clear_done(output int cycles);
    cycles = 0;
    while (clear_busy === 1'b1 && cycles < 3000) begin
      tick();
      cycles++;
    end
    vectors++;
    if (clear_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_timeout: clear_busy=%b after %0d cycles, required 0", clear_busy, cycles);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    #12;
    vectors += 4;
    if (wr_bank !== 1'b0) begin miscompares++; $display("FAIL reset_wr_bank: got %b, required 0", wr_bank); end
    if (clear_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", clear_busy); end
    if (output_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", output_valid); end
    if (output_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h, required 0", output_data); end
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
  endtask

  // Give both banks known random contents so every later read is predictable.
  task automatic fill_all();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < D; a++) write_cell(a, W'($urandom));
      pulse_swap();
    end
  endtask

  task automatic test_ping_pong();
    logic [W-1:0] got; logic vld;
    write_cell(5, 13'h1ABC);
    read_cell(5, got, vld);
    vectors += 2;
    if (got !== m_data) begin miscompares++; $display("FAIL pp_preswap: got %h, required %h", got, m_data); end
    if (vld !== 1'b1) begin miscompares++; $display("FAIL pp_preswap_valid: got %b, required 1", vld); end
    pulse_swap();
    read_cell(5, got, vld);
    vectors += 3;
    if (got !== 13'h1ABC) begin miscompares++; $display("FAIL pp_swapped: got %h, required 1abc", got); end
    if (vld !== 1'b1) begin miscompares++; $display("FAIL pp_valid: got %b, required 1", vld); end
    if (wr_bank !== 1'b1) begin miscompares++; $display("FAIL pp_bank: got %b, required 1", wr_bank); end
    tick();
    vectors += 2;
    if (output_valid !== 1'b0) begin miscompares++; $display("FAIL pp_valid_drop: got %b, required 0", output_valid); end
    if (output_data !== 13'h1ABC) begin miscompares++; $display("FAIL pp_hold: got %h, required 1abc", output_data); end
    pulse_swap();
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      write_enable  = ($urandom_range(0, 1) == 1);
      write_address = AB'($urandom);
      input_data    = W'($urandom);
      read_enable   = ($urandom_range(0, 2) != 0);
      read_address  = AB'($urandom_range(0, 15));
      swap          = ($urandom_range(0, 7) == 0);
      tick();
      vectors += 4;
      if (output_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b, required %b", i, output_valid, m_valid); end
      if (output_data !== m_data) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h, required %h", i, output_data, m_data); end
      if (wr_bank !== m_bank) begin miscompares++; $display("FAIL rnd_bank[%0d]: got %b, required %b", i, wr_bank, m_bank); end
      if (clear_busy !== m_busy) begin miscompares++; $display("FAIL rnd_busy[%0d]: got %b, required %b", i, clear_busy, m_busy); end
    end
    idle_inputs();
    if (m_bank) pulse_swap();
  endtask

  task automatic test_clear();
    logic [W-1:0] got; logic vld; int busy_cycles; int bad;
    for (int a = 0; a < D; a++) write_cell(a, 13'h0F0F);
    clear_start = 1; tick(); clear_start = 0;
    busy_cycles = 0;
    while (clear_busy === 1'b1 && busy_cycles < 3000) begin
      vectors++;
      if (clear_busy !== m_busy) begin miscompares++; $display("FAIL clr_busy_model[%0d]: got %b, required %b", busy_cycles, clear_busy, m_busy); end
      busy_cycles++;
      tick();
    end
    vectors++;
    if (busy_cycles != N) begin miscompares++; $display("FAIL clr_busy_len: got %0d cycles, required %0d", busy_cycles, N); end
    pulse_swap();
    bad = 0;
    for (int a = 0; a < D; a++) begin
      read_cell(a, got, vld);
      vectors++;
      if (got !== m_data) begin
        miscompares++;
        if (bad < 5) $display("FAIL clr_read[%0d]: got %h, required %h", a, got, m_data);
        bad++;
      end
    end
    read_cell(757, got, vld);
    vectors++;
    if (got !== 13'h0F0F) begin miscompares++; $display("FAIL clr_untouched_757: got %h, required 0f0f", got); end
    read_cell(756, got, vld);
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL clr_last_756: got %h, required 0", got); end
    pulse_swap();
  endtask

  task automatic test_clear_priority();
    logic [W-1:0] got; logic vld; int cyc;
    clear_start = 1; tick(); clear_start = 0;
    repeat (10) tick();
    write_enable = 1; write_address = AB'(3); input_data = 13'h1234; swap = 1;
    tick();
    write_enable = 0; swap = 0;
    wait_clear_done(cyc);
    vectors += 2;
    if (wr_bank !== 1'b0) begin miscompares++; $display("FAIL prio_bank: got %b, required 0", wr_bank); end
    if (wr_bank !== m_bank) begin miscompares++; $display("FAIL prio_bank_model: got %b, required %b", wr_bank, m_bank); end
    pulse_swap();
    read_cell(3, got, vld);
    vectors += 2;
    if (got !== '0) begin miscompares++; $display("FAIL prio_addr3: got %h, required 0", got); end
    if (got !== m_data) begin miscompares++; $display("FAIL prio_addr3_model: got %h, required %h", got, m_data); end
    pulse_swap();
  endtask

  task automatic test_swap_and_clear();
    logic [W-1:0] got; logic vld; int cyc;
    for (int a = 0; a < 800; a++) write_cell(a, W'($urandom));
    swap = 1; clear_start = 1; tick(); swap = 0; clear_start = 0;
    wait_clear_done(cyc);
    vectors++;
    if (wr_bank !== 1'b1) begin miscompares++; $display("FAIL sc_bank: got %b, required 1", wr_bank); end
    for (int a = 0; a < 800; a += 7) begin
      read_cell(a, got, vld);
      vectors++;
      if (got !== m_data) begin miscompares++; $display("FAIL sc_bank0[%0d]: got %h, required %h", a, got, m_data); end
    end
    pulse_swap();
    for (int a = 0; a < 800; a += 7) begin
      read_cell(a, got, vld);
      vectors++;
      if (got !== m_data) begin miscompares++; $display("FAIL sc_bank1[%0d]: got %h, required %h", a, got, m_data); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [W-1:0] got; logic vld; logic [W-1:0] keep;
    keep = 13'h0A5A;
    write_cell(200, keep);
    write_cell(150, 13'h0333);
    clear_start = 1; tick(); clear_start = 0;
    while (m_idx < 100) tick();
    rst = 1;
    model_reset();
    #1;
    vectors += 2;
    if (clear_busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b, required 0", clear_busy); end
    if (wr_bank !== 1'b0) begin miscompares++; $display("FAIL mid_bank: got %b, required 0", wr_bank); end
    #1;
    rst = 0;
    tick();
    vectors++;
    if (clear_busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy_after: got %b, required 0", clear_busy); end
    pulse_swap();
    for (int a = 0; a < 210; a++) begin
      read_cell(a, got, vld);
      vectors++;
      if (got !== m_data) begin miscompares++; $display("FAIL mid_read[%0d]: got %h, required %h", a, got, m_data); end
    end
    read_cell(200, got, vld);
    vectors++;
    if (got !== keep) begin miscompares++; $display("FAIL mid_keep200: got %h, required %h", got, keep); end
    pulse_swap();
  endtask

  initial begin
    test_reset();
    fill_all();
    test_ping_pong();
    test_random_traffic();
    test_clear();
    test_clear_priority();
    test_swap_and_clear();
    if (m_bank) pulse_swap();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
